// File: rtl/product_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// accum_pkg
//   Shared types and widths for the product accumulator slice.
//   PROD_W  : width of the multiplier product {c_out, p2, p1, p0}
//   CNT_W   : width of the per-batch product counter
//   state_t : accumulator control states
// ----------------------------------------------------------------------------
package accum_pkg;

    localparam int PROD_W = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// ----------------------------------------------------------------------------
// sat_add
//   Combinational unsigned saturating adder. The PROD_W-bit operand is
//   zero-extended, the sum is formed one bit wider than the accumulator, and
//   any carry out clamps the result to the all-ones maximum.
//
// Ports
//   a    in  ACC_W   running accumulator value
//   b    in  PROD_W  unsigned product to add
//   sum  out ACC_W   a + b, clamped to 2^ACC_W-1
//   sat  out 1       the unclamped sum did not fit in ACC_W bits
// ----------------------------------------------------------------------------
module sat_add
    import accum_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    assign sat      = full_sum[ACC_W];
    assign sum      = sat ? '1 : full_sum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
//   Sums N_SAMPLES unsigned 4-bit multiplier products per batch and presents
//   the (possibly saturated) total downstream. Both sides use valid/ready.
//   in_ready and out_valid are decoded from the registered state only, so
//   there is no combinational path from in_valid/out_ready to them.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      upstream product is valid
//   in_ready   out  1      product accepted this cycle (not in DONE)
//   prod       in   4      unsigned product {c_out, p2, p1, p0}
//   out_valid  out  1      acc_out holds a completed result (DONE)
//   out_ready  in   1      downstream consumes the result
//   acc_out    out  ACC_W  accumulated, saturating sum
//   overflow   out  1      the current batch saturated (sticky)
//   count      out  8      products accepted in the current batch
// ----------------------------------------------------------------------------
module product_accumulator
    import accum_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_SAMPLES);

    state_t            state;
    logic [ACC_W-1:0]  add_a;
    logic [ACC_W-1:0]  add_sum;
    logic              add_sat;
    logic [CNT_W-1:0]  count_next;

    assign in_ready   = (state != DONE);
    assign out_valid  = (state == DONE);
    assign count_next = count + 1'b1;

    // The first product of a batch starts from zero, so IDLE feeds a zero
    // operand rather than relying on acc_out having been cleared.
    assign add_a = (state == IDLE) ? '0 : acc_out;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (add_a),
        .b   (prod),
        .sum (add_sum),
        .sat (add_sat)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc_out  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_out  <= add_sum;
                        overflow <= add_sat;
                        count    <= CNT_W'(1);
                        state    <= (N_SAMPLES == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_out  <= add_sum;
                        // Sticky: once saturated, later adds keep acc at max.
                        overflow <= overflow | add_sat;
                        count    <= count_next;
                        if (count_next == LAST_COUNT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // in_valid is ignored here; the next batch cannot start
                    // on the consume edge.
                    if (out_ready) begin
                        state    <= IDLE;
                        acc_out  <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the two-bit multiplier.
- Consumes its 4-bit unsigned product, formed as {c_out, p2, p1, p0}, through a valid/ready handshake.
- Sums a fixed number of products and presents the sum to the next stage with its own valid/ready handshake.
- Lets lab benches check dot-product-style results, not single products only.

Parameters:
- N_SAMPLES, 4, number of products summed per result (legal range 1..255).
- ACC_W, 8, accumulator and result width in bits (minimum 4).

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream product is valid this cycle.
- in_ready  output  1  block accepts a product this cycle.
- prod  input  4  unsigned product, {c_out, p2, p1, p0} from the multiplier.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  downstream consumes the result this cycle.
- acc_out  output  ACC_W  accumulated (possibly saturated) sum.
- overflow  output  1  this result saturated; valid while out_valid=1.
- count  output  8  products accepted in the current batch.

Behaviour:
- Reset (synchronous, active-high; reset is rst=1 at a rising clk edge):
  - state=IDLE, acc_out=0, count=0, overflow=0, out_valid=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-batch or while in DONE discards the partial or pending result. No output pulse.
- Accept and present rules:
  - A product is accepted on an edge where in_valid=1 and in_ready=1.
  - A result is consumed on an edge where out_valid=1 and out_ready=1.
- States (package enum): IDLE, ACCUM, DONE.
- IDLE: in_ready=1, out_valid=0, acc=0, count=0.
  - On accept: acc=prod, count=1.
  - Next state is DONE if N_SAMPLES=1, otherwise ACCUM.
- ACCUM: in_ready=1, out_valid=0.
  - On accept: acc=sat_add(acc, prod), count=count+1.
  - When count reaches N_SAMPLES -> DONE.
  - No accept: all state holds. Bubbles of any length are allowed.
- DONE: in_ready=0, out_valid=1. acc_out, overflow and count stay stable until consumed.
  - On consume -> IDLE, with acc, count and overflow cleared at that edge.
  - in_valid is ignored in DONE. No product is accepted on the consume edge; the first accept of the next batch is no earlier than the following cycle.
- Latency: out_valid rises on the edge that accepts the N_SAMPLES-th product, i.e. it is visible the cycle after that product is presented.
- Throughput: one batch per N_SAMPLES+1 cycles at best, including the consume cycle.
- Arithmetic:
  - Unsigned. prod is zero-extended to ACC_W.
  - If the ACC_W+1-bit sum exceeds 2^ACC_W-1, acc saturates to 2^ACC_W-1 and overflow is set.
  - overflow is sticky for the rest of the batch. Later adds keep acc at the maximum.
- Input range: all 4-bit prod values 0..15 are accepted. No check against the multiplier's real maximum of 9.
- Output timing: outputs are registered or decoded from registered state only. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

Decomposition:
- Shared package accum_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - PROD_W=4.
  - CNT_W=8.
- One natural sub-module: sat_add, a parameterised (ACC_W) combinational unsigned saturating adder.
  - Inputs a[ACC_W], b[PROD_W].
  - Outputs sum[ACC_W], sat.
  - Instantiated once in product_accumulator.

Test Plan:
- Reset then products 2,3,6,9 back-to-back with out_ready=1 -> out_valid=1 for exactly one cycle, acc_out=20, overflow=0, count=4, in_ready=0 during that cycle.
- Products 1,4 with a 3-cycle in_valid gap between them, then 0,9; out_ready=0 for 5 cycles -> acc_out=14 held stable, out_valid held, in_ready=0 throughout, extra in_valid pulses ignored; consumed when out_ready=1, then IDLE.
- ACC_W=5, products 9,9,9,9 -> acc_out=31, overflow=1. Next batch 1,1,1,1 -> acc_out=4, overflow=0.
- rst=1 after 2 of 4 products (values 5,5) -> next cycle count=0, acc_out=0, out_valid=0, in_ready=1. A fresh batch 1,2,3,4 gives 10.
- N_SAMPLES=1, products 6 then 3 with out_ready=1 -> two results of 6 and 3, each out_valid for one cycle, with in_ready=0 on each DONE cycle.
- Exhaustive: all 16 combinations of 2-bit x and y through the multiplier into the accumulator in groups of 4 -> each acc_out equals the reference sum of x*y for its group.
